// File: rtl/hazard_pkg.sv
//==============================================================================
// Module  : hazard_pkg
// Purpose : Shared tag type, forwarding constants and youngest-match helper
//           for the hazard scoreboard.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

package hazard_pkg;

    localparam int HZ_RD_W      = 8;
    localparam int HZ_MAX_DEPTH = 8;
    localparam int FWD_REGFILE  = 0;

    typedef struct packed {
        logic               valid;
        logic [HZ_RD_W-1:0] rd;
        logic               is_load;
    } hz_tag_t;

    localparam int HZ_TAG_W = $bits(hz_tag_t);

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } hz_match_t;

    // Lowest set bit wins: tag[0] is the youngest writer in flight.
    function automatic hz_match_t youngest_match(input logic [HZ_MAX_DEPTH-1:0] hits);
        hz_match_t m;
        m = '0;
        for (int i = HZ_MAX_DEPTH - 1; i >= 0; i--) begin
            if (hits[i[2:0]]) begin
                m.hit = 1'b1;
                m.idx = i[2:0];
            end
        end
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hz_tag_pipe.sv
//==============================================================================
// Module  : hz_tag_pipe
// Purpose : DEPTH-entry shift register of in-flight writer tags (EX..WB),
//           with an insert-bubble input and asynchronous active-low clear.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

module hz_tag_pipe
    import hazard_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic                      clockCPU,
    input  logic                      reset_n,
    input  logic                      insert_bubble,
    input  logic [HZ_TAG_W-1:0]       tag_in,
    output logic [DEPTH*HZ_TAG_W-1:0] tags
);

    hz_tag_t tag_r [DEPTH];

    always_ff @(posedge clockCPU or negedge reset_n) begin
        if (!reset_n) begin
            tag_r[0] <= '0;
        end else begin
            tag_r[0] <= insert_bubble ? hz_tag_t'('0) : hz_tag_t'(tag_in);
        end
    end

    for (genvar i = 1; i < DEPTH; i++) begin : g_shift
        always_ff @(posedge clockCPU or negedge reset_n) begin
            if (!reset_n) begin
                tag_r[i] <= '0;
            end else begin
                tag_r[i] <= tag_r[i-1];
            end
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_out
        assign tags[i*HZ_TAG_W +: HZ_TAG_W] = tag_r[i];
    end

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
//==============================================================================
// Module  : hazard_scoreboard
// Purpose : RAW hazard detection, registered EX forwarding selects, load-use
//           stall and redirect squash. HAZARD_PERF_CNT_EN adds perf counters.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int FWD_W      = $clog2(DEPTH)
) (
    input  logic              clockCPU,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              ex_redirect,
    output logic              stall,
    output logic              flush_if_id,
    output logic              bubble_id_ex,
    output logic [FWD_W-1:0]  ex_fwd_rs1,
    output logic [FWD_W-1:0]  ex_fwd_rs2
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_events
`endif
);

    hz_tag_t [DEPTH-1:0]     tags;
    hz_tag_t                 tag_in;
    logic [HZ_MAX_DEPTH-1:0] hits1, hits2, early;
    hz_match_t               m1, m2;
    logic                    rs1_ok, rs2_ok, stall_int;

    assign rs1_ok = id_rs1_used && (id_rs1 != '0);
    assign rs2_ok = id_rs2_used && (id_rs2 != '0);

    // The WB entry never matches: the register file is write-first.
    for (genvar j = 0; j < DEPTH; j++) begin : g_match
        assign early[j] = tags[j].is_load && ((j + 1) < LOAD_STAGE);
        assign hits1[j] = (j < DEPTH - 1) && tags[j].valid && rs1_ok
                          && (tags[j].rd == HZ_RD_W'(id_rs1));
        assign hits2[j] = (j < DEPTH - 1) && tags[j].valid && rs2_ok
                          && (tags[j].rd == HZ_RD_W'(id_rs2));
    end

    if (DEPTH < HZ_MAX_DEPTH) begin : g_pad
        assign early[HZ_MAX_DEPTH-1:DEPTH] = '0;
        assign hits1[HZ_MAX_DEPTH-1:DEPTH] = '0;
        assign hits2[HZ_MAX_DEPTH-1:DEPTH] = '0;
    end

    assign m1 = youngest_match(hits1);
    assign m2 = youngest_match(hits2);

    assign stall_int    = id_valid && !ex_redirect
                          && ((m1.hit && early[m1.idx]) || (m2.hit && early[m2.idx]));
    assign stall        = stall_int;
    assign flush_if_id  = reset_n && ex_redirect;
    assign bubble_id_ex = flush_if_id || stall_int;

    always_comb begin
        tag_in         = '0;
        tag_in.valid   = id_valid && id_regwrite && (id_rd != '0);
        tag_in.rd      = HZ_RD_W'(id_rd);
        tag_in.is_load = id_memread;
    end

    hz_tag_pipe #(.DEPTH(DEPTH)) u_tag_pipe (
        .clockCPU      (clockCPU),
        .reset_n       (reset_n),
        .insert_bubble (stall_int || ex_redirect),
        .tag_in        (tag_in),
        .tags          (tags)
    );

    always_ff @(posedge clockCPU or negedge reset_n) begin
        if (!reset_n) begin
            ex_fwd_rs1 <= FWD_W'(FWD_REGFILE);
            ex_fwd_rs2 <= FWD_W'(FWD_REGFILE);
        end else if (stall_int || ex_redirect || !id_valid) begin
            ex_fwd_rs1 <= FWD_W'(FWD_REGFILE);
            ex_fwd_rs2 <= FWD_W'(FWD_REGFILE);
        end else begin
            ex_fwd_rs1 <= m1.hit ? FWD_W'(m1.idx + 3'd1) : FWD_W'(FWD_REGFILE);
            ex_fwd_rs2 <= m2.hit ? FWD_W'(m2.idx + 3'd1) : FWD_W'(FWD_REGFILE);
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clockCPU or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            stall_cycles <= stall_cycles + {31'd0, stall_int};
            flush_events <= flush_events + {31'd0, ex_redirect};
        end
    end
`endif

endmodule

`default_nettype wire

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard and forwarding controller for the in-order RISC-V pipeline.
- Keeps a shadow tag pipeline of in-flight writers from EX through WB.
- Detects RAW hazards for the instruction in ID and emits registered forwarding selects for that instruction's EX cycle.
- Generates load-use stalls for any load latency, and squashes wrong-path instructions on EX redirects (taken branch, jal, jalr).

Parameters:
- REG_AW, 5, register address width.
- DEPTH, 3, tracked stages after ID; tag[0]=EX, tag[DEPTH-1]=WB; range 2..8.
- LOAD_STAGE, 2, index of the first pipeline-register output holding load data (1=EX/MEM, 2=MEM/WB); range 1..DEPTH-1.
- FWD_W, $clog2(DEPTH), width of the forwarding select.

Ports:
- clockCPU  in  1  CPU clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  the ID stage holds a real instruction.
- id_rs1  in  REG_AW  ID source register 1.
- id_rs2  in  REG_AW  ID source register 2.
- id_rs1_used  in  1  the instruction reads rs1.
- id_rs2_used  in  1  the instruction reads rs2.
- id_rd  in  REG_AW  ID destination register.
- id_regwrite  in  1  the ID instruction writes rd.
- id_memread  in  1  the ID instruction is a load.
- ex_redirect  in  1  the EX instruction changes PC this cycle.
- stall  out  1  hold PC and IF/ID; bubble ID/EX.
- flush_if_id  out  1  zero IF/ID (convert to NOP) at the next edge.
- bubble_id_ex  out  1  clear ID/EX control bits at the next edge.
- ex_fwd_rs1  out  FWD_W  EX operand-A source: 0=ID/EX latch, k=output of pipeline register k.
- ex_fwd_rs2  out  FWD_W  EX operand-B source, same encoding.

Behaviour:
- Tag entry fields: {valid, rd, is_load}.
- A tag is written only when id_valid & id_regwrite & (id_rd != 0). Register x0 never matches and never forwards.
- Every cycle the tags shift: tag[i+1] <= tag[i]. tag[0] <= the ID instruction's tag, or an invalid tag when stall or ex_redirect is high.
- Source match (combinational, in ID):
  - A source matches when it is used, its address is nonzero, and it equals a valid tag[j] with j < DEPTH-1.
  - The youngest match (smallest j) wins.
  - tag[DEPTH-1] never needs forwarding: the register file is write-first.
- Forward value: a match at j yields k = j+1, which is the register position during the consumer's EX cycle.
- Load-use stall: stall = id_valid & !ex_redirect & (some winning match has is_load & (j+1) < LOAD_STAGE).
  - Stall is re-evaluated every cycle, so a load stalls for LOAD_STAGE-1-j cycles.
  - Example: LOAD_STAGE=2, load in EX -> exactly 1 stall cycle.
- ex_fwd_rs1 and ex_fwd_rs2 are registered:
  - They load the computed k when the ID instruction advances.
  - They load 0 when stall, ex_redirect or !id_valid is high.
- Redirect: when ex_redirect=1, flush_if_id=1 and bubble_id_ex=1 in the same cycle (combinational). The ID instruction is not entered into tag[0]. Tags already in flight are unaffected.
- Priority:
  - ex_redirect overrides stall; stall is forced to 0 that cycle.
  - Whenever stall=1, bubble_id_ex=1.
- Simultaneous matches on rs1 and rs2 against different producers are resolved independently. Stall is the OR of both operands' stall conditions.
- Reset (asynchronous, any time, including mid-stall): all tags invalid; every output 0; counters 0.
- Outputs are glitch-free relative to clockCPU. Stall and flush depend only on registered tags and ID inputs.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, adds two 32-bit output ports, stall_cycles and flush_events:
  - stall_cycles increments each cycle stall=1.
  - flush_events increments each cycle ex_redirect=1.
  - Both wrap at 2^32 and reset to 0.
- When undefined, these ports and their counters do not exist.

Decomposition:
- Package hazard_pkg:
  - Typedef hz_tag_t {valid, rd[REG_AW], is_load}.
  - Constant FWD_REGFILE = 0.
  - Function youngest_match(), returning {hit, idx}.
- One sub-module: hz_tag_pipe, the DEPTH-entry shift register with asynchronous active-low clear and an insert-bubble input. Match logic and output registers stay in hazard_scoreboard.

Test Plan:
- Parameters DEPTH=3, LOAD_STAGE=2. Dependent ALU ops: add x5 <- (x1, x2), then sub x6 <- (x5, x3) next cycle -> no stall; ex_fwd_rs1=1 during sub's EX.
- One-gap dependency: add x5, nop, then a consumer of x5 -> ex_fwd_rs1=2 during the consumer's EX.
- Load-use: lw x7 followed immediately by add x8 <- (x7, x7) -> stall=1 and bubble_id_ex=1 for exactly 1 cycle, then ex_fwd_rs1=ex_fwd_rs2=2.
- Rebuild with LOAD_STAGE=3, DEPTH=4, same load-use stimulus -> 2 stall cycles, then ex_fwd=3.
- Stall and redirect together: ex_redirect=1 in the same cycle a load-use is detected -> stall=0, flush_if_id=1, bubble_id_ex=1; the next cycle's tag[0] is invalid.
- x0 writes and reset:
  - addi x0 followed by a consumer of x0 -> no stall; ex_fwd=0.
  - Assert reset_n=0 mid-stall -> all outputs 0 immediately; no forward after release.
  - With HAZARD_PERF_CNT_EN defined, counters read 0 after reset.
